// File: rtl/sm_pkg.sv
// sm_pkg: shared types and defaults for the instruction fetch slice
package sm_pkg;
  localparam int INSTR_W = 32;
  localparam int FETCH_DEPTH = 4;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  typedef enum logic {S_IDLE, S_FETCH} fetch_state_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'd3;
  endfunction
endpackage

// File: rtl/sm_fetch_if.sv
// sm_fetch_if: instruction-memory and decode handshakes of the fetch unit
interface sm_fetch_if;
  import sm_pkg::*;
  logic imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic instr_valid, instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [31:0] instr_pc;
  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    input imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );
  modport slave (
    input imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );
endinterface

// File: rtl/sm_fifo.sv
// sm_fifo: synchronous FIFO with occupancy count and single-cycle clear
module sm_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assert property (@(posedge clk) disable iff (reset || clear) !(push && !pop && count == CW'(DEPTH)));
  assert property (@(posedge clk) disable iff (reset || clear) !(pop && count == '0));
endmodule

// File: rtl/sm_fetch.sv
// sm_fetch: prefetching instruction fetch unit; redirect flushes the queue
// and turns every outstanding request into a response to be discarded.
module sm_fetch import sm_pkg::*; #(
  parameter int DEPTH = FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input logic        clk,
  input logic        reset,
  input logic        fetch_en,
  input logic        redirect,
  input logic [31:0] redirect_pc,
  sm_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 2;
  fetch_state_t state, state_n;
  logic [31:0] fetch_pc;
  logic [CW-1:0] live_cnt, drop_cnt, fifo_count;
  logic [OW-1:0] occupancy;
  logic [31:0] pcq [DEPTH];
  logic [AW-1:0] pcq_wr, pcq_rd;
  logic accept, rsp_keep, pop;
  logic [63:0] fifo_dout;
  assign occupancy = OW'(fifo_count) + OW'(live_cnt) + OW'(drop_cnt);
  always_ff @(posedge clk) state <= reset ? S_IDLE : state_n;
  always_comb begin
    state_n = fetch_en ? S_FETCH : S_IDLE;
    bus.imem_req_valid = state == S_FETCH && !redirect && occupancy < OW'(DEPTH);
  end
  assign bus.imem_addr = fetch_pc;
  assign accept = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_keep = bus.imem_rsp_valid && drop_cnt == '0 && !redirect;
  assign bus.instr_valid = fifo_count != '0 && !redirect;
  assign pop = bus.instr_valid && bus.instr_ready;
  assign bus.instr = fifo_count != '0 ? fifo_dout[31:0] : '0;
  assign bus.instr_pc = fifo_count != '0 ? fifo_dout[63:32] : '0;
  always_ff @(posedge clk)
    if (accept) pcq[pcq_wr] <= fetch_pc;
  // Responses arrive in order, so the PC queue head always matches the response, stale or not
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      live_cnt <= '0;
      drop_cnt <= '0;
      pcq_wr <= '0;
      pcq_rd <= '0;
    end else begin
      if (accept) pcq_wr <= pcq_wr + AW'(1);
      if (bus.imem_rsp_valid) pcq_rd <= pcq_rd + AW'(1);
      if (redirect) begin
        fetch_pc <= word_align(redirect_pc);
        live_cnt <= '0;
        drop_cnt <= drop_cnt + live_cnt - CW'(bus.imem_rsp_valid);
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        live_cnt <= live_cnt + CW'(accept) - CW'(bus.imem_rsp_valid && drop_cnt == '0);
        drop_cnt <= drop_cnt - CW'(bus.imem_rsp_valid && drop_cnt != '0);
      end
    end
  end
  sm_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk(clk),
    .reset(reset),
    .clear(redirect),
    .push(rsp_keep),
    .pop(pop),
    .din({pcq[pcq_rd], bus.imem_rsp_data}),
    .dout(fifo_dout),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_sm_fetch.sv
// tb_sm_fetch: randomized and directed checks of sm_fetch against a queue-level model
module tb_sm_fetch;
  import sm_pkg::*;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'hFFFF_FFF8;
  typedef struct {logic [31:0] data; int due;} mrsp_t;
  typedef struct {logic [31:0] pc; bit stale;} inf_t;
  logic clk = 0, reset = 1, fetch_en = 0, redirect = 0;
  logic [31:0] redirect_pc = 0;
  sm_fetch_if bus();
  sm_fetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .bus(bus)
  );
  always #5 clk = ~clk;
  mrsp_t memq[$];
  inf_t inf[$];
  logic [63:0] mfifo[$];
  logic [31:0] m_pc;
  bit m_fetch, e_req, e_iv;
  int cyc, n_chk, n_fail;
  int k_fen, k_rdy, k_irdy, k_rsp, k_lat, k_red;
  int f_red;
  logic [31:0] f_rpc;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask
  task automatic knobs(input int fen, input int rdy, input int irdy, input int rsp, input int lat, input int red);
    k_fen = fen; k_rdy = rdy; k_irdy = irdy; k_rsp = rsp; k_lat = lat; k_red = red;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1; fetch_en = 1; redirect = 0;
    bus.imem_req_ready = 1; bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0; bus.instr_ready = 1;
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
      chk("rst_instr_valid", 32'(bus.instr_valid), 0);
      chk("rst_addr", bus.imem_addr, RPC);
      chk("rst_instr", bus.instr, 0);
      chk("rst_instr_pc", bus.instr_pc, 0);
    end
    memq.delete(); inf.delete(); mfifo.delete();
    m_pc = RPC; m_fetch = 0;
  endtask
  // One clock: drive inputs, compare against the model, then advance the model over the edge
  task automatic step();
    inf_t h;
    @(negedge clk);
    reset = 0;
    fetch_en = $urandom_range(99) < k_fen;
    redirect = f_red >= 0 ? f_red[0] : ($urandom_range(99) < k_red);
    redirect_pc = f_red >= 0 ? f_rpc : ($urandom_range(3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom);
    bus.imem_req_ready = $urandom_range(99) < k_rdy;
    bus.instr_ready = $urandom_range(99) < k_irdy;
    bus.imem_rsp_valid = memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99) < k_rsp;
    bus.imem_rsp_data = bus.imem_rsp_valid ? memq[0].data : $urandom;
    #1;
    e_req = m_fetch && !redirect && (mfifo.size() + inf.size() < DEPTH);
    e_iv = mfifo.size() > 0 && !redirect;
    chk("imem_req_valid", 32'(bus.imem_req_valid), 32'(e_req));
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("instr_valid", 32'(bus.instr_valid), 32'(e_iv));
    if (e_iv) begin
      chk("instr", bus.instr, mfifo[0][31:0]);
      chk("instr_pc", bus.instr_pc, mfifo[0][63:32]);
    end
    if (e_iv && bus.instr_ready) void'(mfifo.pop_front());
    if (bus.imem_rsp_valid) begin
      h = inf.pop_front();
      void'(memq.pop_front());
      if (!h.stale && !redirect) mfifo.push_back({h.pc, bus.imem_rsp_data});
    end
    if (redirect) begin
      mfifo.delete();
      for (int i = 0; i < inf.size(); i++) inf[i].stale = 1;
      m_pc = redirect_pc & ~32'd3;
    end else if (e_req && bus.imem_req_ready) begin
      inf.push_back('{pc: m_pc, stale: 1'b0});
      memq.push_back('{data: $urandom, due: cyc + int'($urandom_range(k_lat, 1))});
      m_pc += 32'd4;
    end
    m_fetch = fetch_en;
    cyc++;
  endtask
  initial begin
    int n;
    bit got;
    f_red = -1; f_rpc = 0; cyc = 0; n_chk = 0; n_fail = 0;
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0; bus.instr_ready = 0;
    // streaming from reset across the address wrap
    knobs(100, 100, 100, 100, 1, 0);
    do_reset(); cyc = 0;
    step(); chk("c0_req_valid", 32'(bus.imem_req_valid), 0);
    step(); chk("c1_req_valid", 32'(bus.imem_req_valid), 1); chk("c1_addr", bus.imem_addr, 32'hFFFF_FFF8);
    step(); chk("c2_addr", bus.imem_addr, 32'hFFFF_FFFC); chk("c2_instr_valid", 32'(bus.instr_valid), 0);
    step(); chk("c3_addr", bus.imem_addr, 32'h0); chk("c3_instr_valid", 32'(bus.instr_valid), 1);
    chk("c3_instr_pc", bus.instr_pc, 32'hFFFF_FFF8);
    step(); chk("c4_addr", bus.imem_addr, 32'h4); chk("c4_instr_pc", bus.instr_pc, 32'hFFFF_FFFC);
    step(); chk("c5_instr_pc", bus.instr_pc, 32'h0);
    // decode stalled: fill to DEPTH, then one pop admits one request
    knobs(100, 100, 0, 100, 1, 0);
    do_reset(); cyc = 0; n = 0;
    repeat (10) begin
      step();
      if (bus.imem_req_valid && bus.imem_req_ready) n++;
    end
    chk("bp_req_count", 32'(n), 4);
    chk("bp_stalled", 32'(bus.imem_req_valid), 0);
    knobs(100, 100, 100, 100, 1, 0);
    step(); chk("bp_pop_valid", 32'(bus.instr_valid), 1);
    knobs(100, 100, 0, 100, 1, 0);
    step(); chk("bp_refill_req", 32'(bus.imem_req_valid), 1); chk("bp_refill_addr", bus.imem_addr, 32'h8);
    step(); chk("bp_full_again", 32'(bus.imem_req_valid), 0);
    // redirect with three requests outstanding
    knobs(100, 100, 100, 0, 1, 0);
    do_reset(); cyc = 0;
    repeat (4) step();
    f_red = 1; f_rpc = 32'h103;
    step(); chk("rd_req_blocked", 32'(bus.imem_req_valid), 0); chk("rd_instr_valid", 32'(bus.instr_valid), 0);
    f_red = -1; knobs(100, 100, 100, 100, 1, 0);
    step(); chk("rd_req_valid", 32'(bus.imem_req_valid), 1); chk("rd_addr", bus.imem_addr, 32'h100);
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      if (bus.instr_valid) begin
        got = 1;
        chk("rd_first_pc", bus.instr_pc, 32'h100);
      end
    end
    chk("rd_first_seen", 32'(got), 1);
    // redirect coinciding with a response while the FIFO holds three entries
    knobs(100, 100, 0, 100, 1, 0);
    do_reset(); cyc = 0;
    repeat (5) step();
    f_red = 1; f_rpc = 32'h200;
    step(); chk("rf_instr_valid", 32'(bus.instr_valid), 0);
    f_red = -1; knobs(100, 100, 100, 100, 1, 0);
    step(); chk("rf_empty", 32'(bus.instr_valid), 0); chk("rf_req_valid", 32'(bus.imem_req_valid), 1);
    chk("rf_addr", bus.imem_addr, 32'h200);
    step(); step();
    chk("rf_first_valid", 32'(bus.instr_valid), 1); chk("rf_first_pc", bus.instr_pc, 32'h200);
    // randomized traffic, with a reset dropped into the middle
    do_reset(); cyc = 0;
    for (int p = 0; p < 5; p++) begin
      if (p == 0) knobs(90, 70, 70, 70, 3, 2);
      if (p == 1) knobs(100, 100, 30, 100, 1, 1);
      if (p == 2) knobs(70, 50, 90, 40, 6, 5);
      if (p == 3) begin
        do_reset();
        knobs(95, 80, 60, 80, 4, 3);
      end
      if (p == 4) knobs(100, 100, 100, 100, 1, 0);
      repeat (2000) step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sm_fetch.md
SM_FETCH -- requirements
Module: sm_fetch

Interface
REQ-001 Parameter DEPTH, default 4, number of prefetch FIFO entries and in-flight request limit; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 fetch_en  in  1  permits new memory requests while high.
REQ-007 redirect  in  1  branch taken (PCSrc from the controller); flush and refetch.
REQ-008 redirect_pc  in  32  new fetch address; bits [1:0] ignored.
REQ-009 imem_req_valid  out  1  instruction memory request valid.
REQ-010 imem_req_ready  in  1  memory accepts request.
REQ-011 imem_addr  out  32  request word address; [1:0] always 2'b00.
REQ-012 imem_rsp_valid  in  1  response data valid; responses return in request order, at least 1 cycle after acceptance.
REQ-013 imem_rsp_data  in  32  instruction word.
REQ-014 instr_valid  out  1  Instr available to the controller/decode.
REQ-015 instr_ready  in  1  controller consumes Instr.
REQ-016 instr  out  32  instruction word (controller uses [31:12]).
REQ-017 instr_pc  out  32  address of instr.

Function
REQ-018 FSM states S_IDLE, S_FETCH; S_IDLE -> S_FETCH when fetch_en=1; S_FETCH -> S_IDLE when fetch_en=0; in-flight responses still land in S_IDLE.
REQ-019 Request issued (imem_req_valid=1) only in S_FETCH, redirect=0, and fifo_count + live_cnt + drop_cnt < DEPTH.
REQ-020 Accepted request (valid&ready): fetch_pc <= fetch_pc + 4, wrapping 32'hFFFF_FFFC -> 32'h0; live_cnt +1; issued address pushed to in-flight PC queue.
REQ-021 imem_addr = fetch_pc; imem_req_valid may drop without acceptance (no hold obligation).
REQ-022 Response with drop_cnt>0: discarded, drop_cnt -1; else pushed to FIFO with its PC, live_cnt -1.
REQ-023 No bypass: response in cycle N earliest appears on instr_valid in cycle N+1.
REQ-024 instr/instr_pc driven from FIFO head; instr_valid = FIFO non-empty AND redirect=0; pop on instr_valid & instr_ready.
REQ-025 Push and pop in the same cycle permitted at any occupancy, count unchanged; overflow impossible by REQ-019, assertion required.
REQ-026 Redirect cycle: no request, no pop, FIFO cleared, fetch_pc <= {redirect_pc[31:2],2'b00}, drop_cnt <= drop_cnt + live_cnt minus any response arriving that cycle (that response discarded), live_cnt <= 0.
REQ-027 Redirect held several cycles: each cycle re-applies REQ-026; last redirect_pc wins.
REQ-028 Redirect while fetch_en=0 updates fetch_pc and flush identically.

Reset
REQ-029 Reset: state S_IDLE, fetch_pc=RESET_PC, FIFO empty, live_cnt=0, drop_cnt=0.
REQ-030 Outputs during/after reset: imem_req_valid=0, instr_valid=0, imem_addr=RESET_PC, instr=0, instr_pc=0.
REQ-031 Reset mid-operation abandons in-flight requests; memory subsystem is reset with the same signal, so no responses return after reset.

Structure
REQ-032 Shared package sm_pkg holds fetch state enum, FETCH_DEPTH default, RESET_PC default, INSTR_W=32.
REQ-033 One sub-module sm_fifo (synchronous FIFO, DEPTH x 64 bits {pc,instr}, count output, clear input); PC queue of in-flight requests in sm_fetch.

Verification
REQ-034 Reset, fetch_en=1, memory ready, 1-cycle latency, instr_ready=1 -> addresses 0,4,8,... consecutive cycles; instr_pc 0 valid first at cycle 3 after reset release.
REQ-035 instr_ready=0 with DEPTH=4 -> exactly 4 requests issued (0x0..0xC), then imem_req_valid=0; one pop -> one new request 0x10.
REQ-036 Three requests in flight, redirect=1 redirect_pc=0x103 -> next request 0x100; three stale responses discarded; first instr_pc=0x100.
REQ-037 Redirect coincident with response and full FIFO -> instr_valid=0 that cycle, FIFO empty next cycle, response discarded, drop_cnt correct.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> request sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 Random imem_req_ready/rsp latency/instr_ready, 10k cycles -> delivered (pc,instr) stream matches reference model, no overflow assertion.
